// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: pass/fail monitor for riscv-tests programs (register-watch or tohost store-watch).
// Latency: verdict registered SETTLE_CYCLES+1 cycles after the completing write/store; busy rises the cycle after start.
// Backpressure: none; passively snoops the register-file write port and store bus, never stalls the core.
//
// Ports: clk / rst_n        clock, asynchronous active-low reset
//        start              one-cycle pulse: clear all status and arm
//        rf_we/waddr/wdata  register-file write snoop
//        st_valid/addr/wdata accepted data-store snoop
//        retire             one instruction retired this cycle
//        busy/done/pass/fail/timeout/fail_testnum  registered verdict
//        cycle_count/retire_count                  saturating activity counters
module riscv_test_monitor #(
  parameter int          MODE           = 0,
  parameter int          DONE_REG       = 26,
  parameter int          RESULT_REG     = 27,
  parameter int          TESTNUM_REG    = 3,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          SETTLE_CYCLES  = 2,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic        retire,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] fail_testnum,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, REPORT} state_t;

  localparam logic [4:0]  DONE_IDX     = 5'(DONE_REG);
  localparam logic [4:0]  RESULT_IDX   = 5'(RESULT_REG);
  localparam logic [4:0]  TESTNUM_IDX  = 5'(TESTNUM_REG);
  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          STORE_MODE   = (MODE != 0);
  localparam bit          HAS_SETTLE   = (SETTLE_CYCLES != 0);
  localparam bit          HAS_TIMEOUT  = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic [7:0]  settle_cnt;
  logic [31:0] testnum_sh;
  logic [31:0] result_sh;
  logic        st_pass_sh;   // tohost verdict captured at completion
  logic [31:0] st_tn_sh;

  logic        rf_ok;
  logic        done_hit;
  logic        tohost_hit;
  logic        complete;
  logic        timeout_hit;
  logic [31:0] testnum_nxt;
  logic [31:0] result_nxt;
  logic        st_pass_now;
  logic [31:0] st_tn_now;
  logic        fin_pass;
  logic [31:0] fin_tn;
  logic [31:0] cycle_nxt;
  logic [31:0] retire_nxt;
  logic        unused_addr_lsb;

  // Byte offset within the tohost word does not matter.
  assign unused_addr_lsb = ^st_addr[1:0];

  always_comb begin
    // x0 is never a real destination, whatever the parameters say.
    rf_ok       = rf_we && (rf_waddr != 5'd0);
    done_hit    = rf_ok && (rf_waddr == DONE_IDX) && (rf_wdata == 32'd1);
    tohost_hit  = st_valid && (st_addr[31:2] == TOHOST_ADDR[31:2]) && (st_wdata != 32'd0);
    complete    = STORE_MODE ? tohost_hit : done_hit;
    // cycle_count only advances in RUN before SETTLE, so in RUN it is the RUN cycle index.
    timeout_hit = HAS_TIMEOUT && (cycle_count == TIMEOUT_LAST);
    // Next-shadow values let a write in the verdict cycle itself take part.
    testnum_nxt = (rf_ok && (rf_waddr == TESTNUM_IDX)) ? rf_wdata : testnum_sh;
    result_nxt  = (rf_ok && (rf_waddr == RESULT_IDX)) ? rf_wdata : result_sh;
    st_pass_now = (st_wdata == 32'd1);
    st_tn_now   = {1'b0, st_wdata[31:1]};
    if (STORE_MODE) begin
      fin_pass = (state == RUN) ? st_pass_now : st_pass_sh;
      fin_tn   = (state == RUN) ? st_tn_now : st_tn_sh;
    end else begin
      fin_pass = (result_nxt == 32'd1);
      fin_tn   = testnum_nxt;
    end
    cycle_nxt  = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
    retire_nxt = (retire && (retire_count != '1)) ? retire_count + 32'd1 : retire_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= 8'd0;
      testnum_sh   <= 32'd0;
      result_sh    <= 32'd0;
      st_pass_sh   <= 1'b0;
      st_tn_sh     <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= 32'd0;
      cycle_count  <= 32'd0;
      retire_count <= 32'd0;
    end else if (start) begin
      state        <= RUN;
      settle_cnt   <= 8'd0;
      testnum_sh   <= 32'd0;
      result_sh    <= 32'd0;
      st_pass_sh   <= 1'b0;
      st_tn_sh     <= 32'd0;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= 32'd0;
      cycle_count  <= 32'd0;
      retire_count <= 32'd0;
    end else begin
      case (state)
        RUN, SETTLE: begin
          cycle_count  <= cycle_nxt;
          retire_count <= retire_nxt;
          testnum_sh   <= testnum_nxt;
          result_sh    <= result_nxt;
          if (state == RUN) begin
            // Completion is checked first so it wins over a same-cycle timeout.
            if (complete) begin
              st_pass_sh <= st_pass_now;
              st_tn_sh   <= st_tn_now;
              if (HAS_SETTLE) begin
                state      <= SETTLE;
                settle_cnt <= SETTLE_LAST;
              end else begin
                state        <= REPORT;
                busy         <= 1'b0;
                done         <= 1'b1;
                pass         <= fin_pass;
                fail         <= !fin_pass;
                fail_testnum <= fin_pass ? 32'd0 : fin_tn;
              end
            end else if (timeout_hit) begin
              state        <= REPORT;
              busy         <= 1'b0;
              done         <= 1'b1;
              fail         <= 1'b1;
              timeout      <= 1'b1;
              fail_testnum <= testnum_nxt;
            end
          end else if (settle_cnt == 8'd0) begin
            state        <= REPORT;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= fin_pass;
            fail         <= !fin_pass;
            fail_testnum <= fin_pass ? 32'd0 : fin_tn;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        IDLE, REPORT: ;  // wait for start; REPORT holds the verdict
        default: state <= IDLE;
      endcase
    end
  end

endmodule
